// File: rtl/main_mem_responder.sv
`default_nettype none
// =============================================================================
// main_mem_responder : latency-modelled line-burst memory behind the data cache.
// Optional feature macro: MEM_CRITICAL_WORD_FIRST_EN.  Rev 1.0
// =============================================================================
module main_mem_responder #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int WORDS_PER_LINE = 4,
  parameter int LATENCY        = 3,
  parameter int MEM_WORDS      = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  wr_valid,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ready,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_last,
  output logic                  resp_done
);

  localparam int IDX_W  = $clog2(MEM_WORDS);
  localparam int BEAT_W = $clog2(WORDS_PER_LINE);
  localparam int LAT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [LAT_W-1:0]  LAT_LOAD  = (LATENCY > 0) ? LAT_W'(LATENCY - 1) : '0;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS_PER_LINE - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT     = 3'd1,
    S_RD_BURST = 3'd2,
    S_WR_BURST = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  state_t             state;
  logic [IDX_W-1:0]   base;
  logic [BEAT_W-1:0]  start;
  logic [BEAT_W-1:0]  beat;
  logic               is_write;
  logic [LAT_W-1:0]   lat_cnt;

  logic [IDX_W-1:0]   req_idx;
  logic [IDX_W-1:0]   req_base;
  logic [BEAT_W-1:0]  req_start;
  logic [IDX_W-1:0]   src_base;
  logic [BEAT_W-1:0]  src_start;
  logic [BEAT_W-1:0]  rd_off;
  logic [BEAT_W-1:0]  rd_beat;
  logic [IDX_W-1:0]   rd_idx;
  logic [IDX_W-1:0]   wr_idx;
  logic               go_burst;
  logic               go_write;
  logic               we;
  logic               unused_addr_bits;

  assign req_idx  = req_addr[2 +: IDX_W];
  assign req_base = req_idx & ~IDX_W'(WORDS_PER_LINE - 1);
`ifdef MEM_CRITICAL_WORD_FIRST_EN
  assign req_start = req_idx[BEAT_W-1:0];
`else
  assign req_start = '0;
`endif
  assign unused_addr_bits = ^{req_addr[ADDR_WIDTH-1:2+IDX_W], req_addr[1:0]};

  // The first beat can launch straight from IDLE (zero latency), before the
  // request fields have been latched, so the read address comes from a mux.
  assign src_base  = (state == S_IDLE) ? req_base  : base;
  assign src_start = (state == S_IDLE) ? req_start : start;
  assign rd_off    = (state == S_RD_BURST) ? beat : '0;
  assign rd_beat   = src_start + rd_off;
  assign rd_idx    = src_base | IDX_W'(rd_beat);
  assign wr_idx    = base | IDX_W'(beat);

  assign go_burst = ((state == S_IDLE) && req_ready && req_valid && (LATENCY == 0)) ||
                    ((state == S_WAIT) && (lat_cnt == '0));
  assign go_write = (state == S_IDLE) ? req_write : is_write;
  assign we       = rst_n && (state == S_WR_BURST) && wr_valid;

  always_ff @(posedge clk) begin
    if (we) mem[wr_idx] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      req_ready <= 1'b0;
      wr_ready  <= 1'b0;
      rd_valid  <= 1'b0;
      rd_last   <= 1'b0;
      rd_data   <= '0;
      resp_done <= 1'b0;
      base      <= '0;
      start     <= '0;
      beat      <= '0;
      is_write  <= 1'b0;
      lat_cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!req_ready) begin
            req_ready <= 1'b1;
          end else if (req_valid) begin
            req_ready <= 1'b0;
            base      <= req_base;
            start     <= req_start;
            is_write  <= req_write;
            state     <= S_WAIT;
            lat_cnt   <= LAT_LOAD;
          end
        end
        S_WAIT: lat_cnt <= lat_cnt - 1'b1;
        S_RD_BURST: begin
          if (rd_last) begin
            state     <= S_DONE;
            rd_valid  <= 1'b0;
            rd_last   <= 1'b0;
            resp_done <= 1'b1;
          end else begin
            rd_data <= mem[rd_idx];
            rd_last <= (beat == LAST_BEAT);
            beat    <= beat + 1'b1;
          end
        end
        S_WR_BURST: begin
          if (wr_valid) begin
            beat <= beat + 1'b1;
            if (beat == LAST_BEAT) begin
              state     <= S_DONE;
              wr_ready  <= 1'b0;
              resp_done <= 1'b1;
            end
          end
        end
        S_DONE: begin
          resp_done <= 1'b0;
          req_ready <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      // Burst launch overrides the per-state updates above.
      if (go_burst) begin
        if (go_write) begin
          state    <= S_WR_BURST;
          wr_ready <= 1'b1;
          beat     <= '0;
        end else begin
          state    <= S_RD_BURST;
          rd_valid <= 1'b1;
          rd_last  <= 1'b0;
          rd_data  <= mem[rd_idx];
          beat     <= BEAT_W'(1);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_main_mem_responder.sv
`default_nettype none
// =============================================================================
// tb_main_mem_responder : directed self-checking bench (LATENCY=3 and LATENCY=0).
// =============================================================================
module tb_main_mem_responder;

  localparam int LAT = 3;

  logic        clk;
  logic        rst_n;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr;
  logic        wr_valid, wr_ready;
  logic [31:0] wr_data;
  logic        rd_valid, rd_last, resp_done;
  logic [31:0] rd_data;

  logic        z_req_valid, z_req_ready, z_req_write;
  logic [31:0] z_req_addr;
  logic        z_wr_valid, z_wr_ready;
  logic [31:0] z_wr_data;
  logic        z_rd_valid, z_rd_last, z_resp_done;
  logic [31:0] z_rd_data;

  int total = 0;
  int bad   = 0;

  main_mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .WORDS_PER_LINE(4),
                       .LATENCY(LAT), .MEM_WORDS(1024)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last),
    .resp_done(resp_done)
  );

  main_mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .WORDS_PER_LINE(4),
                       .LATENCY(0), .MEM_WORDS(1024)) dut_zero (
    .clk(clk), .rst_n(rst_n),
    .req_valid(z_req_valid), .req_ready(z_req_ready), .req_write(z_req_write),
    .req_addr(z_req_addr),
    .wr_valid(z_wr_valid), .wr_data(z_wr_data), .wr_ready(z_wr_ready),
    .rd_valid(z_rd_valid), .rd_data(z_rd_data), .rd_last(z_rd_last),
    .resp_done(z_resp_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $error("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called in a cycle with req_ready=1; returns in the next such cycle.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] d, input bit stall);
    int n;
    req_valid = 1'b1; req_write = 1'b1; req_addr = addr;
    step();
    req_valid = 1'b0; req_write = 1'b0;
    chk("wr_accept_ready_low", 32'(req_ready), 32'd0);
    wr_valid = 1'b1; wr_data = 32'hDEAD_BEEF;   // must be ignored while waiting
    n = 1;
    while (!wr_ready && n < 20) begin step(); n++; end
    chk("wr_ready_latency", 32'(n), 32'(LAT + 1));
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1; wr_data = d + 32'(i);
      step();
      if (stall && i == 1) begin
        wr_valid = 1'b0; wr_data = 32'hBAD0_0000;
        chk("stall_ready_1", 32'(wr_ready), 32'd1);
        step();
        chk("stall_ready_2", 32'(wr_ready), 32'd1);
        step();
      end
    end
    wr_valid = 1'b0;
    chk("wr_done_pulse", 32'(resp_done), 32'd1);
    chk("wr_ready_dropped", 32'(wr_ready), 32'd0);
    step();
    chk("wr_idle_ready", 32'(req_ready), 32'd1);
    chk("wr_done_cleared", 32'(resp_done), 32'd0);
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [31:0] e0, input logic [31:0] e1,
                         input logic [31:0] e2, input logic [31:0] e3);
    int n;
    logic [31:0] e [4];
    e = '{e0, e1, e2, e3};
    req_valid = 1'b1; req_write = 1'b0; req_addr = addr;
    step();
    req_valid = 1'b0;
    n = 1;
    while (!rd_valid && n < 20) begin step(); n++; end
    chk("rd_first_beat_latency", 32'(n), 32'(LAT + 1));
    for (int i = 0; i < 4; i++) begin
      chk("rd_valid", 32'(rd_valid), 32'd1);
      chk("rd_data", rd_data, e[i]);
      chk("rd_last", 32'(rd_last), (i == 3) ? 32'd1 : 32'd0);
      step();
    end
    chk("rd_valid_end", 32'(rd_valid), 32'd0);
    chk("rd_done_pulse", 32'(resp_done), 32'd1);
    chk("rd_data_hold", rd_data, e3);
    step();
    chk("rd_idle_ready", 32'(req_ready), 32'd1);
    chk("rd_done_cleared", 32'(resp_done), 32'd0);
  endtask

  initial begin
    int n, hits, beats;
    logic [31:0] first;

    rst_n = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; wr_valid = 1'b0; wr_data = '0;
    z_req_valid = 1'b0; z_req_write = 1'b0; z_req_addr = '0; z_wr_valid = 1'b0; z_wr_data = '0;
    repeat (3) step();
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_wr_ready", 32'(wr_ready), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rd_last", 32'(rd_last), 32'd0);
    chk("rst_rd_data", rd_data, 32'd0);
    chk("rst_resp_done", 32'(resp_done), 32'd0);
    rst_n = 1'b1;
    chk("rst_release_same_cycle", 32'(req_ready), 32'd0);
    step();
    chk("rst_release_ready", 32'(req_ready), 32'd1);

    // Write then read back, then a stalled write-back.
    do_write(32'h40, 32'hA0, 1'b0);
    do_read(32'h40, 32'hA0, 32'hA1, 32'hA2, 32'hA3);
    do_write(32'h80, 32'hB0, 1'b1);
    do_read(32'h80, 32'hB0, 32'hB1, 32'hB2, 32'hB3);

    // Refill to word 2 of the line.
`ifdef MEM_CRITICAL_WORD_FIRST_EN
    do_read(32'h48, 32'hA2, 32'hA3, 32'hA0, 32'hA1);
`else
    do_read(32'h48, 32'hA0, 32'hA1, 32'hA2, 32'hA3);
`endif

    // 0x1040 aliases 0x40 in a 1024-word array.
    do_write(32'h1040, 32'hC0, 1'b0);
    do_read(32'h40, 32'hC0, 32'hC1, 32'hC2, 32'hC3);

    // req_valid held through a whole read: exactly two acceptances.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h80;
    hits = 0;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (req_ready) hits++;
    end
    chk("busy_ready_low", 32'(hits), 32'd0);
    step();
    chk("busy_ready_back", 32'(req_ready), 32'd1);
    step();
    req_valid = 1'b0;
    chk("busy_accept_once", 32'(req_ready), 32'd0);
    beats = 0; first = '0;
    for (int k = 0; k < 16; k++) begin
      if (rd_valid) begin
        if (beats == 0) first = rd_data;
        beats++;
      end
      step();
    end
    chk("busy_second_beats", 32'(beats), 32'd4);
    chk("busy_second_first", first, 32'hB0);
    chk("busy_final_ready", 32'(req_ready), 32'd1);

    // Reset during beat 2 of a read.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h40;
    step();
    req_valid = 1'b0;
    n = 1;
    while (!rd_valid && n < 20) begin step(); n++; end
    step(); step();
    chk("mid_rst_beat2_valid", 32'(rd_valid), 32'd1);
    chk("mid_rst_beat2_data", rd_data, 32'hC2);
    rst_n = 1'b0;
    step();
    chk("mid_rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("mid_rst_rd_last", 32'(rd_last), 32'd0);
    chk("mid_rst_rd_data", rd_data, 32'd0);
    chk("mid_rst_resp_done", 32'(resp_done), 32'd0);
    chk("mid_rst_req_ready", 32'(req_ready), 32'd0);
    chk("mid_rst_wr_ready", 32'(wr_ready), 32'd0);
    rst_n = 1'b1;
    step();
    chk("mid_rst_release_ready", 32'(req_ready), 32'd1);
    do_read(32'h40, 32'hC0, 32'hC1, 32'hC2, 32'hC3);

    // Zero-latency instance: beat/ready in cycle T+1.
    z_req_valid = 1'b1; z_req_write = 1'b1; z_req_addr = 32'h0;
    step();
    z_req_valid = 1'b0; z_req_write = 1'b0;
    chk("z_wr_ready_t1", 32'(z_wr_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      z_wr_valid = 1'b1; z_wr_data = 32'hD0 + 32'(i);
      step();
    end
    z_wr_valid = 1'b0;
    chk("z_wr_done", 32'(z_resp_done), 32'd1);
    step();
    chk("z_idle_ready", 32'(z_req_ready), 32'd1);
    z_req_valid = 1'b1; z_req_write = 1'b0; z_req_addr = 32'h0;
    step();
    z_req_valid = 1'b0;
    chk("z_rd_valid_t1", 32'(z_rd_valid), 32'd1);
    chk("z_rd_data0", z_rd_data, 32'hD0);
    step();
    chk("z_rd_data1", z_rd_data, 32'hD1);
    step(); step();
    chk("z_rd_last", 32'(z_rd_last), 32'd1);
    chk("z_rd_data3", z_rd_data, 32'hD3);
    step();
    chk("z_rd_done", 32'(z_resp_done), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
